// File: rtl/ram_pkg.sv
// Grid RAM types shared by the occupancy datapath and its readout engine.
package ram_pkg;
  localparam int WIDTH_BITS   = 3;
  localparam int HEIGHT_BITS  = 3;
  localparam int WORD_BITS    = 16;
  localparam int ADDRESS_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam int GRID_CELLS   = (1 << WIDTH_BITS) * (1 << HEIGHT_BITS);

  typedef logic signed [WORD_BITS-1:0] word_t;
  typedef logic [ADDRESS_BITS-1:0]     address_t;
  typedef logic [WIDTH_BITS-1:0]       width_index_t;
  typedef logic [HEIGHT_BITS-1:0]      height_index_t;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} readout_state_t;

  typedef struct packed {
    logic          last;
    height_index_t y;
    width_index_t  x;
  } cell_tag_t;

  typedef struct packed {
    word_t     data;
    cell_tag_t tag;
  } beat_t;

  // Row-major: y selects the row, x the column within it.
  function automatic address_t index_to_address(input width_index_t x, input height_index_t y);
    return {y, x};
  endfunction
endpackage

// File: rtl/readout_fifo.sv
// Small synchronous FIFO of readout beats; head is zeroed while empty.
module readout_fifo
  import ram_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           push,
  input  beat_t                          push_beat,
  input  logic                           pop,
  output beat_t                          head,
  output logic                           not_empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [PTR_W-1:0]            ptr_t;
  typedef logic [$clog2(DEPTH+1)-1:0]  cnt_t;

  beat_t mem [DEPTH];
  ptr_t  wr_ptr, rd_ptr;
  logic  do_pop;

  function automatic ptr_t bump(input ptr_t p);
    return (p == ptr_t'(DEPTH-1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign head      = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_beat;

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: ;
      endcase
    end
endmodule

// File: rtl/occupancy_readout.sv
// Raster-order grid readout: fixed-latency RAM reads turned into a
// back-pressurable stream, credit-limited so the FIFO can never overflow.
module occupancy_readout
  import ram_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          ram_read_enable,
  output address_t      ram_address,
  input  word_t         ram_data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output word_t         out_data,
  output width_index_t  out_x,
  output height_index_t out_y,
  output logic          out_last
);
  localparam int FIFO_DEPTH = READ_LATENCY + 2;
  localparam int COUNT_W    = $clog2(FIFO_DEPTH + 1);

  readout_state_t state;
  width_index_t   x_issue;
  height_index_t  y_issue;
  logic [READ_LATENCY:1] vld_pipe;
  cell_tag_t      tag_pipe [READ_LATENCY:1];
  logic [COUNT_W-1:0] fifo_count;
  logic           issue, pop, last_cell;
  beat_t          push_beat, head;

  assign last_cell = (&x_issue) && (&y_issue);
  assign pop       = out_valid && out_ready;

  // Reads in the tag pipe plus stored beats never exceed the FIFO depth.
  always_comb
    issue = (state == READ) &&
            (($countones(vld_pipe) + int'(fifo_count)) < FIFO_DEPTH);

  assign ram_read_enable = issue;
  assign ram_address     = index_to_address(x_issue, y_issue);

  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      x_issue <= '0;
      y_issue <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= READ;
          busy    <= 1'b1;
          x_issue <= '0;
          y_issue <= '0;
        end
        READ: if (issue) begin
          x_issue <= x_issue + width_index_t'(1);
          if (&x_issue) y_issue <= y_issue + height_index_t'(1);
          if (last_cell) state <= DRAIN;
        end
        DRAIN: if (pop && out_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end

  // Clearing the valid bits on reset drops any read still inside the RAM.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= issue;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end

  always_ff @(posedge clock) begin
    tag_pipe[1] <= '{last: last_cell, y: y_issue, x: x_issue};
    for (int i = 2; i <= READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
  end

  assign push_beat = '{data: ram_data_out, tag: tag_pipe[READ_LATENCY]};

  readout_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (vld_pipe[READ_LATENCY]),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .not_empty (out_valid),
    .count     (fifo_count)
  );

  assign out_data = head.data;
  assign out_x    = head.tag.x;
  assign out_y    = head.tag.y;
  assign out_last = head.tag.last;
endmodule

// File: doc/occupancy_readout.md
# occupancy_readout

Streams the whole occupancy grid out of grid RAM in raster order (x fastest, then y) over a valid/ready interface, for host upload and map export. It is the read-side counterpart of the occupancy update datapath: it owns a read port on the grid RAM and converts fixed-latency RAM reads into a back-pressurable stream. A credit-limited output FIFO guarantees that no read result is ever dropped while the consumer stalls.

## Interface
- `READ_LATENCY`, default 1: grid RAM read latency in cycles. Legal values are 1 and 2.
- `FIFO_DEPTH`, default `READ_LATENCY+2` (derived, not overridable): output buffer depth.

- `clock` in 1: single clock for the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin one full-grid readout. Sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the final beat is accepted.
- `ram_read_enable` out 1: read strobe to the grid RAM.
- `ram_address` out `address_t`: read address, equal to `index_to_address(x_issue, y_issue)`.
- `ram_data_out` in `word_t`: RAM read data, valid `READ_LATENCY` cycles after the strobe.
- `out_valid` out 1: a stream beat is available.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out `word_t`: cell value (signed log-odds word, passed through unmodified).
- `out_x` out `width_index_t`: x index of the beat.
- `out_y` out `height_index_t`: y index of the beat.
- `out_last` out 1: marks cell (all-ones, all-ones).

## Operation
- FSM states:
  - IDLE: `start` moves the FSM to READ. Issue counters are cleared. The FIFO is already empty.
  - READ: reads are issued. After the last cell is issued, the FSM moves to DRAIN.
  - DRAIN: no further reads are issued. When the beat with `out_last` is accepted, the FSM moves to IDLE and `done` pulses.
- Issue rule: a read is issued in a READ cycle iff `in_flight + fifo_count < FIFO_DEPTH`.
  - An issue drives `ram_read_enable`=1 and advances `x_issue`.
  - When `x_issue` wraps from all-ones, `y_issue` increments.
  - Cell (all-ones, all-ones) is the last cell issued.
- Each issue pushes an (x, y, last) tag into a `READ_LATENCY`-deep tag shift register. The tag and `ram_data_out` are written into the FIFO together.
- FIFO pop occurs on `out_valid & out_ready`. While the FIFO is non-empty, the head `out_*` values are held stable.
- A simultaneous push and pop leaves `fifo_count` unchanged.
- `start` during READ or DRAIN is ignored. `start` held high through IDLE after `done` begins a new readout.
- Reset (any state) forces the following. In-flight RAM data arriving after reset deassertion is discarded.
  - FSM → IDLE.
  - Counters, credit count and FIFO pointers → 0.
  - Tag-shift valid bits → 0.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_read_enable`=0, `out_valid`=0, `out_last`=0, `ram_address`=0, `out_data`/`out_x`/`out_y`=0.
- Taking `start` sampled at edge 0:
  - FSM is in READ after edge 0.
  - The first address is presented in cycle 0–1.
  - `out_valid` first rises after edge `READ_LATENCY+1`.
- With `out_ready` held high, one beat is produced per cycle with no bubbles. A grid of N cells completes (`done` high) N+`READ_LATENCY`+1 cycles after edge 0.
- Stall: the FIFO never overflows. At most `FIFO_DEPTH` entries are counted as in flight plus stored. Issue resumes the cycle after a pop frees a credit.
- `done` is asserted in the cycle following the edge that accepts the `out_last` beat. `busy` falls in that same cycle.

## Structure
- `ram_pkg` provides `word_t`, `address_t`, `width_index_t` and `height_index_t`.
- Add to `ram_pkg`:
  - `readout_state_t` enum (IDLE, READ, DRAIN).
  - `GRID_CELLS` constant.
- Reuse the existing `index_to_address` for `ram_address`.
- One natural sub-module is `readout_fifo`: a synchronous FIFO parameterised by depth, holding {data, x, y, last}, exposing `count`.

## Test plan
- Package grid 8×8, `READ_LATENCY`=1, RAM preloaded with value = address, `out_ready`=1, `start` pulsed:
  - Beats 0..63 in order, with `out_x`=i%8, `out_y`=i/8, `out_data`=i.
  - `out_last` only on beat 63.
  - `done` 66 cycles after start.
- Same setup with `READ_LATENCY`=2: first `out_valid` after edge 3, no bubbles, `done` at cycle 67.
- Random `out_ready` (50%) with RAM preloaded -1 (all-ones):
  - Every cell appears exactly once with value -1.
  - `out_*` are stable during stalls.
  - `in_flight+fifo_count` ≤ `FIFO_DEPTH` at all times.
- `out_ready`=0 for 20 cycles after start: exactly `FIFO_DEPTH` reads are issued, then `ram_read_enable` stays 0 until the first pop.
- `start` re-pulsed mid-READ: ignored, a single 64-beat stream. `start` held through `done`: a second full stream begins.
- `reset_n` asserted at beat 30 with a read in flight:
  - All outputs go to reset values immediately.
  - No stale beat appears afterwards.
  - A new `start` restarts at (0,0).
